// File: rtl/rv32i_pkg.sv
// rv32i_pkg: shared datapath widths and load funct3 encodings
package rv32i_pkg;
  localparam int XLEN = 32;
  localparam int REG_ADDR_W = 5;
  typedef enum logic [2:0] {
    LB  = 3'b000,
    LH  = 3'b001,
    LW  = 3'b010,
    LBU = 3'b100,
    LHU = 3'b101
  } load_funct3_e;
endpackage

// File: rtl/load_extract.sv
// load_extract: byte/halfword/word selection and extension of a loaded memory word
module load_extract
  import rv32i_pkg::*;
(
  input  logic [2:0]      funct3,
  input  logic [1:0]      addr_lsb,
  input  logic [XLEN-1:0] word,
  output logic [XLEN-1:0] value
);
  logic [7:0]  b;
  logic [15:0] h;
  always_comb begin
    b = word[8*addr_lsb +: 8];
    h = word[16*addr_lsb[1] +: 16];
    value = funct3 == LB  ? {{(XLEN-8){b[7]}}, b} :
            funct3 == LH  ? {{(XLEN-16){h[15]}}, h} :
            funct3 == LBU ? {{(XLEN-8){1'b0}}, b} :
            funct3 == LHU ? {{(XLEN-16){1'b0}}, h} :
            word;
  end
endmodule

// File: rtl/wb_regfile.sv
// wb_regfile: writeback select and architectural register file with WB->ID bypass
module wb_regfile
  import rv32i_pkg::*;
#(
  parameter int NREGS = 32,
  parameter bit BYPASS_EN = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [REG_ADDR_W-1:0] rd_wb,
  input  logic                  reg_wr_wb,
  input  logic                  load_wb,
  input  logic [2:0]            funct3_wb,
  input  logic [1:0]            addr_lsb_wb,
  input  logic [XLEN-1:0]       alu_data_wb,
  input  logic [XLEN-1:0]       dm_data_wb,
  input  logic [REG_ADDR_W-1:0] rs1_id,
  input  logic [REG_ADDR_W-1:0] rs2_id,
  output logic [XLEN-1:0]       rs1_data,
  output logic [XLEN-1:0]       rs2_data,
  output logic [XLEN-1:0]       wb_data,
  output logic                  wb_valid,
  input  logic [REG_ADDR_W-1:0] dbg_idx,
  output logic [XLEN-1:0]       dbg_data
);
  logic [XLEN-1:0] regs [NREGS];
  logic [XLEN-1:0] ld_value;
  logic            byp1, byp2;
  load_extract u_load_extract (
    .funct3  (funct3_wb),
    .addr_lsb(addr_lsb_wb),
    .word    (dm_data_wb),
    .value   (ld_value)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n)
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    else if (wb_valid)
      regs[rd_wb] <= wb_data;
  // bypass is gated by rst_n so every read port shows cleared state during reset
  always_comb begin
    wb_data  = load_wb ? ld_value : alu_data_wb;
    wb_valid = reg_wr_wb && rd_wb != '0;
    byp1     = BYPASS_EN && rst_n && wb_valid && rs1_id == rd_wb;
    byp2     = BYPASS_EN && rst_n && wb_valid && rs2_id == rd_wb;
    rs1_data = rs1_id == '0 ? '0 : byp1 ? wb_data : regs[rs1_id];
    rs2_data = rs2_id == '0 ? '0 : byp2 ? wb_data : regs[rs2_id];
    dbg_data = dbg_idx == '0 ? '0 : regs[dbg_idx];
  end
endmodule

// File: doc/wb_regfile.md
Name: wb_regfile

Overview:
Writeback-side consumer of the MEM/WB pipeline register, and owner of the architectural integer register file.
- Selects the writeback value: ALU result, or a load result sign/zero-extracted from the data-memory word.
- Commits that value to x1..x31.
- Serves the two decode-stage read ports, with same-cycle write-to-read bypass.
- Sits between mem_wb (writer) and id_ex / hazard logic (readers).

Parameters:
XLEN, 32, datapath width in bits
NREGS, 32, number of architectural registers (x0..x31)
BYPASS_EN, 1, 1 = same-cycle WB->read forwarding; 0 = reads return stored value only

Ports:
clk  input  1  pipeline clock, rising edge
rst_n  input  1  asynchronous active-low reset
rd_wb  input  5  destination register index from MEM/WB
reg_wr_wb  input  1  writeback enable from MEM/WB
load_wb  input  1  1 = write back load data, 0 = write back ALU data
funct3_wb  input  3  load size/sign: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU
addr_lsb_wb  input  2  byte offset of the load address (alu_data_wb[1:0])
alu_data_wb  input  XLEN  ALU result from MEM/WB
dm_data_wb  input  XLEN  raw aligned data-memory word from MEM/WB
rs1_id  input  5  read port 1 index
rs2_id  input  5  read port 2 index
rs1_data  output  XLEN  read port 1 data
rs2_data  output  XLEN  read port 2 data
wb_data  output  XLEN  selected writeback value, exported for forwarding to EX
wb_valid  output  1  reg_wr_wb && rd_wb != 0; qualifies wb_data for forwarding
dbg_idx  input  5  debug read index
dbg_data  output  XLEN  debug read data, never bypassed

Behaviour:
Reset:
- While rst_n = 0, all registers are cleared asynchronously.
- rs1_data, rs2_data and dbg_data therefore read 0 during reset.
- wb_data and wb_valid are combinational from the inputs and are not affected by reset.

Load extraction (combinational):
- Byte select: dm_data_wb[8*addr_lsb_wb +: 8].
- Halfword select: dm_data_wb[16*addr_lsb_wb[1] +: 16]; addr_lsb_wb[0] is ignored for halfwords.
- LB / LH sign-extend; LBU / LHU zero-extend; LW passes the full word and ignores addr_lsb_wb.
- Undefined funct3 (011, 110, 111) passes the full word unchanged.

Writeback select:
- wb_data = load_wb ? extracted load value : alu_data_wb.

Write:
- On a rising clk edge with rst_n = 1, reg_wr_wb = 1 and rd_wb != 0: regs[rd_wb] <= wb_data.
- Writes to x0 are discarded; x0 always reads 0.
- Write latency is 1 cycle; the value is visible in storage from the next cycle.

Read ports:
- Combinational; index 0 always returns 0.
- If BYPASS_EN = 1 and wb_valid = 1 and rs*_id == rd_wb, the port returns wb_data in the same cycle.
- This removes the WB->ID structural hazard.

Simultaneous events:
- Both read ports addressing rd_wb both receive the bypassed value.
- Reset asserted mid-write: reset wins and the write is lost.
- Reset deasserted coincident with a clock edge: that edge performs no write.

Decomposition:
- Shared package rv32i_pkg:
  - XLEN, REG_ADDR_W = 5
  - enum load_funct3_e {LB=3'b000, LH=3'b001, LW=3'b010, LBU=3'b100, LHU=3'b101}
- Sub-module load_extract (combinational: funct3, addr_lsb, word -> extended value), instantiated once.
- The register array and the bypass logic stay in wb_regfile.

Test Plan:
1. Hold rst_n = 0 with writes attempted (rd_wb = 5, reg_wr_wb = 1); release -> rs1_data = rs2_data = dbg_data = 0 for every index.
2. Write rd = 3, ALU 0x1234_5678, load_wb = 0 -> same cycle rs1_id = 3 gives 0x1234_5678 (bypass); next cycle dbg_idx = 3 gives 0x1234_5678.
3. Write rd = 0 with 0xFFFF_FFFF -> wb_valid = 0; rs1_id = 0 gives 0 both in the same cycle and the next.
4. dm = 0x80FF_7F01, load_wb = 1:
   - LB, off 3 -> 0xFFFF_FF80
   - LBU, off 3 -> 0x0000_0080
   - LH, off 2 -> 0xFFFF_80FF
   - LHU, off 0 -> 0x0000_7F01
   - LW -> 0x80FF_7F01
   Each written to x7 and checked via dbg_data.
5. reg_wr_wb = 0 with rd_wb = 9 and data 0xDEAD_BEEF -> x9 keeps its old value; no bypass.
6. Write x10 = 0xA, then assert rst_n = 0 between clock edges in the next cycle -> x10 reads 0 immediately, before any clock edge.
